// File: rtl/axi4_lite_fanout_pkg.sv
// Shared types for the AXI4-Lite read/write fanout blocks.
// The routing state is one-hot so the active port can be read straight from the state bits.
package axi4_lite_fanout_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    LO_ADDR = 3'b010,
    HI_ADDR = 3'b100
  } fanout_state_t;

  // Master port index served by a routing state (LO -> 0, HI -> 1).
  function automatic logic state_port(input fanout_state_t s);
    return (s == HI_ADDR);
  endfunction

endpackage

// File: rtl/axi4_lite_outstanding_cnt.sv
// Outstanding-transaction counter for one fanout routing session.
// Increments on request handshake, decrements on response handshake, saturation is left to the caller.
module axi4_lite_outstanding_cnt
  import axi4_lite_fanout_pkg::*;
#(
  parameter int D = 4,
  localparam int CW = $clog2(D + 1)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec) begin
      count_d = count_q + CW'(1);
    end else if (dec && !inc) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(D));

endmodule

// File: rtl/axi4_lite_fanout_rd.sv
// AXI4-Lite read fanout: one slave read port routed to two masters by an address boundary M.
// Only one master is served at a time so R beats stay in AR order; the port switches only when nothing is outstanding.
module axi4_lite_fanout_rd
  import axi4_lite_fanout_pkg::*;
#(
  parameter int          A = 32,
  parameter int          N = 4,
  parameter logic [A-1:0] M = 'h1000,
  parameter int          I = 1,
  parameter int          D = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // slave port
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [A-1:0]          s_araddr,
  input  logic [2:0]            s_arprot,
  input  logic [I-1:0]          s_arid,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [8*N-1:0]        s_rdata,
  output logic [1:0]            s_rresp,
  output logic [I-1:0]          s_rid,
  output logic                  s_awready,
  output logic                  s_wready,
  output logic                  s_bvalid,
  // master ports
  output logic [1:0]            m_arvalid,
  input  logic [1:0]            m_arready,
  output logic [1:0][A-1:0]     m_araddr,
  output logic [1:0][2:0]       m_arprot,
  output logic [1:0][I-1:0]     m_arid,
  input  logic [1:0]            m_rvalid,
  output logic [1:0]            m_rready,
  input  logic [1:0][8*N-1:0]   m_rdata,
  input  logic [1:0][1:0]       m_rresp,
  input  logic [1:0][I-1:0]     m_rid,
  output logic [1:0]            m_awvalid,
  output logic [1:0]            m_wvalid,
  output logic [1:0]            m_bready
);

  localparam int CW = $clog2(D + 1);

  fanout_state_t state_q;
  fanout_state_t state_d;

  logic          addr_hi;
  logic          active;
  logic          port;
  logic          tgt_ok;
  logic          cnt_empty;
  logic          cnt_full;
  logic [CW-1:0] cnt_count_unused;

  assign addr_hi = (s_araddr >= M);
  assign active  = (state_q == LO_ADDR) || (state_q == HI_ADDR);
  assign port    = state_port(state_q);
  assign tgt_ok  = active && s_arvalid && (addr_hi == port);

  axi4_lite_outstanding_cnt #(.D(D)) u_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .inc     (s_arvalid && s_arready),
    .dec     (s_rvalid && s_rready),
    .count   (cnt_count_unused),
    .empty   (cnt_empty),
    .full    (cnt_full)
  );

  // A session ends once drained and the next read (if any) belongs to the other port.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (s_arvalid) begin
          state_d = addr_hi ? HI_ADDR : LO_ADDR;
        end
      end
      LO_ADDR, HI_ADDR: begin
        if (cnt_empty && !tgt_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    m_arvalid = '0;
    m_rready  = '0;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = m_rdata[port];
    s_rresp   = m_rresp[port];
    s_rid     = m_rid[port];
    if (active) begin
      m_arvalid[port] = tgt_ok && !cnt_full;
      s_arready       = m_arready[port] && tgt_ok && !cnt_full;
      s_rvalid        = m_rvalid[port];
      m_rready[port]  = s_rready;
    end
  end

  assign m_araddr  = {s_araddr, s_araddr};
  assign m_arprot  = {s_arprot, s_arprot};
  assign m_arid    = {s_arid, s_arid};

  // Write channels are unused on this read-only fanout.
  assign s_awready = 1'b0;
  assign s_wready  = 1'b0;
  assign s_bvalid  = 1'b0;
  assign m_awvalid = 2'b00;
  assign m_wvalid  = 2'b00;
  assign m_bready  = 2'b11;

endmodule

// File: tb/tb_axi4_lite_fanout_rd.sv
// Bench for axi4_lite_fanout_rd: upstream read master, two latency-programmable targets and an in-order scoreboard.
module tb_axi4_lite_fanout_rd;
  localparam int          A = 32;
  localparam int          N = 4;
  localparam int          I = 1;
  localparam int          D = 4;
  localparam logic [31:0] M = 32'h1000;

  logic               aclk;
  logic               aresetn;
  logic               s_arvalid, s_arready;
  logic [31:0]        s_araddr;
  logic [2:0]         s_arprot;
  logic [I-1:0]       s_arid;
  logic               s_rvalid, s_rready;
  logic [31:0]        s_rdata;
  logic [1:0]         s_rresp;
  logic [I-1:0]       s_rid;
  logic               s_awready, s_wready, s_bvalid;
  logic [1:0]         m_arvalid, m_arready;
  logic [1:0][31:0]   m_araddr;
  logic [1:0][2:0]    m_arprot;
  logic [1:0][I-1:0]  m_arid;
  logic [1:0]         m_rvalid, m_rready;
  logic [1:0][31:0]   m_rdata;
  logic [1:0][1:0]    m_rresp;
  logic [1:0][I-1:0]  m_rid;
  logic [1:0]         m_awvalid, m_wvalid, m_bready;

  axi4_lite_fanout_rd #(.A(A), .N(N), .M(M), .I(I), .D(D)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_arid(s_arid), .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rid(s_rid), .s_awready(s_awready), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arprot(m_arprot), .m_arid(m_arid), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rid(m_rid), .m_awvalid(m_awvalid),
    .m_wvalid(m_wvalid), .m_bready(m_bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0]  addr;
    logic [I-1:0] id;
  } req_t;

  typedef struct {
    logic [31:0]  addr;
    logic [I-1:0] id;
    int           due;
  } tgt_t;

  req_t        req_q[$];
  req_t        exp_q[$];
  tgt_t        tq[2][$];
  int          lat[2];
  bit          ar_rand, rready_rand, rready_low;
  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  int          m_ar_count[2];
  int          m_arvalid_seen[2];
  int          ar_cycles[$];
  int          r_cycles[$];
  logic [31:0] last_rdata;
  logic [1:0]  last_rresp;
  logic        snap_s_rvalid;
  logic [31:0] snap_s_rdata;
  logic [1:0]  snap_m_rready;
  logic [31:0] cap_addr[2];
  logic [I-1:0] cap_id[2];

  // Targets derive data from their own port number, so a misrouted read returns a different word.
  function automatic int port_of(input logic [31:0] a);
    return (a >= M) ? 1 : 0;
  endfunction

  function automatic logic [31:0] tgt_data(input int p, input logic [31:0] a);
    return ((p == 1) ? 32'h5A5A_0000 : 32'hA5A5_0000) ^ (a ^ 32'h40);
  endfunction

  function automatic logic [1:0] tgt_resp(input int p, input logic [31:0] a);
    return (p == 1 && a[4]) ? 2'b10 : 2'b00;
  endfunction

  task automatic drive_upstream();
    if (req_q.size() > 0) begin
      s_arvalid = 1'b1;
      s_araddr  = req_q[0].addr;
      s_arid    = req_q[0].id;
      s_arprot  = 3'b010;
    end else begin
      s_arvalid = 1'b0;
    end
  endtask

  task automatic issue(input logic [31:0] addr, input logic [I-1:0] id);
    req_t r;
    r.addr = addr;
    r.id   = id;
    req_q.push_back(r);
    drive_upstream();
  endtask

  task automatic clear_bench();
    req_q.delete();
    exp_q.delete();
    tq[0].delete();
    tq[1].delete();
    s_arvalid   = 1'b0;
    s_araddr    = '0;
    s_arprot    = '0;
    s_arid      = '0;
    s_rready    = 1'b1;
    m_rvalid    = '0;
    m_rdata     = '0;
    m_rresp     = '0;
    m_rid       = '0;
    m_arready   = 2'b11;
    ar_rand     = 1'b0;
    rready_rand = 1'b0;
    rready_low  = 1'b0;
  endtask

  // One clock: observe and score at the falling edge, then advance targets and upstream just after the rising edge.
  task automatic step();
    bit       hs_s_ar, hs_s_r;
    bit [1:0] hs_m_ar, hs_m_r;
    req_t     e;
    tgt_t     t;
    @(negedge aclk);
    cycle++;
    hs_s_ar       = s_arvalid && s_arready;
    hs_s_r        = s_rvalid && s_rready;
    snap_s_rvalid = s_rvalid;
    snap_s_rdata  = s_rdata;
    snap_m_rready = m_rready;
    for (int i = 0; i < 2; i++) begin
      hs_m_ar[i]  = m_arvalid[i] && m_arready[i];
      hs_m_r[i]   = m_rvalid[i] && m_rready[i];
      cap_addr[i] = m_araddr[i];
      cap_id[i]   = m_arid[i];
      if (m_arvalid[i]) begin
        m_arvalid_seen[i]++;
        checks++;
        if (port_of(s_araddr) != i || (exp_q.size() > 0 && port_of(exp_q[0].addr) != i)) begin
          failures++;
          $display("[TB] FAIL route: m_arvalid[%0d]=1 araddr=%h outstanding=%0d required port %0d", i, s_araddr, exp_q.size(), port_of(s_araddr));
        end
      end
      if (hs_m_ar[i]) begin
        m_ar_count[i]++;
        checks++;
        if (m_araddr[i] !== s_araddr || m_arid[i] !== s_arid || m_arprot[i] !== s_arprot) begin
          failures++;
          $display("[TB] FAIL ar_forward: m%0d addr=%h id=%h prot=%h required addr=%h id=%h prot=%h", i, m_araddr[i], m_arid[i], m_arprot[i], s_araddr, s_arid, s_arprot);
        end
      end
    end
    if (s_arvalid && exp_q.size() >= D) begin
      checks++;
      if (s_arready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL full_stall: s_arready=%b with %0d outstanding, required 0", s_arready, exp_q.size());
      end
    end
    if (hs_s_r) begin
      r_cycles.push_back(cycle);
      last_rdata = s_rdata;
      last_rresp = s_rresp;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL r_unexpected: rdata=%h with no read outstanding", s_rdata);
      end else begin
        e = exp_q.pop_front();
        if (s_rdata !== tgt_data(port_of(e.addr), e.addr) || s_rresp !== tgt_resp(port_of(e.addr), e.addr) || s_rid !== e.id) begin
          failures++;
          $display("[TB] FAIL r_data: addr=%h got data=%h resp=%b id=%h required data=%h resp=%b id=%h", e.addr, s_rdata, s_rresp, s_rid, tgt_data(port_of(e.addr), e.addr), tgt_resp(port_of(e.addr), e.addr), e.id);
        end
      end
    end
    if (hs_s_ar) begin
      ar_cycles.push_back(cycle);
      checks++;
      if (hs_m_ar[port_of(s_araddr)] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL ar_pair: slave AR accepted, m%0d handshake=%b required 1", port_of(s_araddr), hs_m_ar[port_of(s_araddr)]);
      end
      e.addr = s_araddr;
      e.id   = s_arid;
      exp_q.push_back(e);
    end

    @(posedge aclk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (hs_m_ar[i]) begin
        t.addr = cap_addr[i];
        t.id   = cap_id[i];
        t.due  = cycle + lat[i];
        tq[i].push_back(t);
      end
      if (hs_m_r[i]) begin
        m_rvalid[i] = 1'b0;
        tq[i].delete(0);
      end
      if (!m_rvalid[i] && tq[i].size() > 0 && tq[i][0].due <= cycle) begin
        m_rvalid[i] = 1'b1;
        m_rdata[i]  = tgt_data(i, tq[i][0].addr);
        m_rresp[i]  = tgt_resp(i, tq[i][0].addr);
        m_rid[i]    = tq[i][0].id;
      end
      m_arready[i] = ar_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    if (hs_s_ar) req_q.delete(0);
    drive_upstream();
    s_rready = rready_low ? 1'b0 : (rready_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic run_until_drained(input int budget, input string name);
    int n;
    n = 0;
    while ((req_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (req_q.size() > 0 || exp_q.size() > 0) begin
      failures++;
      $display("[TB] FAIL %s_timeout: pending=%0d outstanding=%0d after %0d cycles, required 0/0", name, req_q.size(), exp_q.size(), budget);
    end
  endtask

  task automatic test_reset();
    clear_bench();
    aresetn   = 1'b0;
    s_arvalid = 1'b1;
    s_araddr  = 32'h40;
    m_rvalid  = 2'b11;
    repeat (2) @(negedge aclk);
    checks += 8;
    if (s_arready !== 1'b0) begin failures++; $display("[TB] FAIL reset_arready: got %b required 0", s_arready); end
    if (s_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rvalid: got %b required 0", s_rvalid); end
    if (m_arvalid !== 2'b00) begin failures++; $display("[TB] FAIL reset_m_arvalid: got %b required 00", m_arvalid); end
    if (m_rready !== 2'b00) begin failures++; $display("[TB] FAIL reset_m_rready: got %b required 00", m_rready); end
    if ({s_awready, s_wready, s_bvalid} !== 3'b000) begin failures++; $display("[TB] FAIL tieoff_s: got %b required 000", {s_awready, s_wready, s_bvalid}); end
    if (m_awvalid !== 2'b00) begin failures++; $display("[TB] FAIL tieoff_awvalid: got %b required 00", m_awvalid); end
    if (m_wvalid !== 2'b00) begin failures++; $display("[TB] FAIL tieoff_wvalid: got %b required 00", m_wvalid); end
    if (m_bready !== 2'b11) begin failures++; $display("[TB] FAIL tieoff_bready: got %b required 11", m_bready); end
    m_rvalid  = 2'b00;
    s_arvalid = 1'b0;
    @(posedge aclk);
    #1 aresetn = 1'b1;
    idle(2);
  endtask

  task automatic test_single_lo();
    int c0, seen1;
    idle(3);
    lat[0] = 2; lat[1] = 2;
    ar_cycles.delete(); r_cycles.delete();
    c0    = cycle;
    seen1 = m_arvalid_seen[1];
    issue(32'h0000_0040, 1'b0);
    run_until_drained(100, "single_lo");
    checks += 3;
    if (ar_cycles.size() != 1 || ar_cycles[0] - c0 != 2) begin
      failures++;
      $display("[TB] FAIL decode_bubble: accepts=%0d at offset %0d, required 1 at offset 2", ar_cycles.size(), ar_cycles[0] - c0);
    end
    if (last_rdata !== 32'hA5A5_0000) begin failures++; $display("[TB] FAIL single_rdata: got %h required a5a50000", last_rdata); end
    if (m_arvalid_seen[1] != seen1) begin failures++; $display("[TB] FAIL single_m1_quiet: m1 arvalid cycles %0d required 0", m_arvalid_seen[1] - seen1); end
  endtask

  task automatic test_boundary();
    int seen0, cnt0, cnt1;
    idle(3);
    seen0 = m_arvalid_seen[0];
    cnt1  = m_ar_count[1];
    issue(M, 1'b1);
    run_until_drained(100, "boundary");
    checks += 4;
    if (m_arvalid_seen[0] != seen0) begin failures++; $display("[TB] FAIL boundary_m0_quiet: m0 arvalid cycles %0d required 0", m_arvalid_seen[0] - seen0); end
    if (m_ar_count[1] != cnt1 + 1) begin failures++; $display("[TB] FAIL boundary_m1_ar: got %0d required %0d", m_ar_count[1], cnt1 + 1); end
    if (last_rresp !== 2'b00) begin failures++; $display("[TB] FAIL boundary_rresp: got %b required 00", last_rresp); end
    if (last_rdata !== 32'h5A5A_1040) begin failures++; $display("[TB] FAIL boundary_rdata: got %h required 5a5a1040", last_rdata); end
    idle(3);
    cnt0 = m_ar_count[0];
    issue(M - 32'd4, 1'b0);
    run_until_drained(100, "below_boundary");
    checks++;
    if (m_ar_count[0] != cnt0 + 1) begin failures++; $display("[TB] FAIL below_boundary_m0_ar: got %0d required %0d", m_ar_count[0], cnt0 + 1); end
  endtask

  task automatic test_full_stall();
    int n;
    idle(3);
    lat[0] = 20;
    ar_cycles.delete(); r_cycles.delete();
    for (int k = 0; k < 5; k++) issue(32'h10 + 32'(4 * k), 1'(k));
    n = 0;
    while (r_cycles.size() == 0 && n < 100) begin step(); n++; end
    checks++;
    if (ar_cycles.size() != D) begin failures++; $display("[TB] FAIL full_accepts: got %0d before first R, required %0d", ar_cycles.size(), D); end
    run_until_drained(200, "full_stall");
    checks++;
    if (ar_cycles.size() != 5 || ar_cycles[4] <= r_cycles[0]) begin
      failures++;
      $display("[TB] FAIL full_fifth: accepts=%0d fifth at %0d first R at %0d, required 5 and fifth later", ar_cycles.size(), ar_cycles[4], r_cycles[0]);
    end
    lat[0] = 2;
  endtask

  task automatic test_cross_port();
    idle(3);
    lat[0] = 10; lat[1] = 2;
    ar_cycles.delete(); r_cycles.delete();
    issue(32'h0000_0020, 1'b0);
    issue(32'h0000_2000, 1'b1);
    run_until_drained(200, "cross_port");
    checks++;
    if (ar_cycles.size() != 2 || r_cycles.size() != 2 || ar_cycles[1] <= r_cycles[0]) begin
      failures++;
      $display("[TB] FAIL cross_order: 2nd AR at %0d, port0 R at %0d, required AR after R", ar_cycles[1], r_cycles[0]);
    end
    lat[0] = 2;
  endtask

  task automatic test_backpressure();
    int n;
    logic [31:0] expd;
    idle(3);
    lat[1]     = 1;
    rready_low = 1'b1;
    s_rready   = 1'b0;
    expd       = tgt_data(1, 32'h1004);
    issue(32'h0000_1004, 1'b0);
    n = 0;
    while (!snap_s_rvalid && n < 20) begin step(); n++; end
    checks++;
    if (!snap_s_rvalid) begin failures++; $display("[TB] FAIL bp_timeout: s_rvalid=%b after 20 cycles, required 1", snap_s_rvalid); end
    for (int k = 0; k < 8; k++) begin
      step();
      checks += 3;
      if (snap_s_rvalid !== 1'b1) begin failures++; $display("[TB] FAIL bp_rvalid: cycle %0d got %b required 1", k, snap_s_rvalid); end
      if (snap_s_rdata !== expd) begin failures++; $display("[TB] FAIL bp_rdata: cycle %0d got %h required %h", k, snap_s_rdata, expd); end
      if (snap_m_rready[1] !== 1'b0) begin failures++; $display("[TB] FAIL bp_m1_rready: cycle %0d got %b required 0", k, snap_m_rready[1]); end
    end
    rready_low = 1'b0;
    run_until_drained(50, "backpressure");
  endtask

  task automatic test_async_reset();
    int n, c0;
    idle(3);
    lat[0] = 30;
    ar_cycles.delete(); r_cycles.delete();
    for (int k = 0; k < 4; k++) issue(32'h100 + 32'(4 * k), 1'b0);
    n = 0;
    while (ar_cycles.size() < 3 && n < 20) begin step(); n++; end
    checks++;
    if (ar_cycles.size() != 3) begin failures++; $display("[TB] FAIL pre_reset_accepts: got %0d required 3", ar_cycles.size()); end
    #2 aresetn = 1'b0;
    #1;
    checks += 4;
    if (s_arready !== 1'b0) begin failures++; $display("[TB] FAIL areset_arready: got %b required 0", s_arready); end
    if (s_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL areset_rvalid: got %b required 0", s_rvalid); end
    if (m_arvalid !== 2'b00) begin failures++; $display("[TB] FAIL areset_m_arvalid: got %b required 00", m_arvalid); end
    if (m_rready !== 2'b00) begin failures++; $display("[TB] FAIL areset_m_rready: got %b required 00", m_rready); end
    clear_bench();
    @(negedge aclk);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    idle(2);
    lat[0] = 40;
    ar_cycles.delete(); r_cycles.delete();
    c0 = cycle;
    for (int k = 0; k < 5; k++) issue(32'h200 + 32'(4 * k), 1'b1);
    n = 0;
    while (r_cycles.size() == 0 && n < 100) begin step(); n++; end
    checks += 2;
    if (ar_cycles.size() != D) begin failures++; $display("[TB] FAIL post_reset_count: accepts %0d before first R, required %0d", ar_cycles.size(), D); end
    if (ar_cycles[0] - c0 != 2) begin failures++; $display("[TB] FAIL post_reset_idle: first accept at offset %0d, required 2", ar_cycles[0] - c0); end
    run_until_drained(300, "post_reset");
    lat[0] = 2;
  endtask

  task automatic test_random();
    logic [31:0] a;
    int ar0, r0;
    idle(3);
    ar_rand     = 1'b1;
    rready_rand = 1'b1;
    lat[0]      = $urandom_range(1, 6);
    lat[1]      = $urandom_range(1, 6);
    ar0 = ar_cycles.size();
    r0  = r_cycles.size();
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: a = {20'h0, $urandom_range(0, 32'h3FF) * 4};
        1: a = M + 32'($urandom_range(1, 32'h3FFF) * 4);
        2: a = M;
        default: a = M - 32'd4;
      endcase
      issue(a, 1'($urandom_range(0, 1)));
    end
    run_until_drained(4000, "random");
    checks += 2;
    if (ar_cycles.size() - ar0 != 40) begin failures++; $display("[TB] FAIL random_ar_count: got %0d required 40", ar_cycles.size() - ar0); end
    if (r_cycles.size() - r0 != 40) begin failures++; $display("[TB] FAIL random_r_count: got %0d required 40", r_cycles.size() - r0); end
    ar_rand     = 1'b0;
    rready_rand = 1'b0;
  endtask

  initial begin
    lat[0] = 2; lat[1] = 2;
    m_ar_count[0] = 0; m_ar_count[1] = 0;
    m_arvalid_seen[0] = 0; m_arvalid_seen[1] = 0;
    last_rdata = '0; last_rresp = '0;
    snap_s_rvalid = 1'b0; snap_s_rdata = '0; snap_m_rready = '0;
    test_reset();
    test_single_lo();
    test_boundary();
    test_full_stall();
    test_cross_port();
    test_backpressure();
    test_async_reset();
    test_random();
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
